ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/ex_mem_stage.sv | 115 +++++++++++
 tb/tb_ex_mem_stage.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, ctrl bit positions, pipeline-stage
// state encoding, and the entry record held by the EX/MEM stage.
package cpu_pkg;

    localparam int DEFAULT_N  = 16;
    localparam int DEFAULT_RA = 4;
    localparam int CTRL_W     = 4;

    // ctrl = {regwrite, memtoreg, memwrite, branch}
    localparam int CTRL_REGWRITE = 3;
    localparam int CTRL_MEMTOREG = 2;
    localparam int CTRL_MEMWRITE = 1;
    localparam int CTRL_BRANCH   = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    typedef struct packed {
        logic [DEFAULT_N-1:0]  alu;
        logic [DEFAULT_N-1:0]  wdata;
        logic [DEFAULT_RA-1:0] waddr;
        logic [DEFAULT_N-1:0]  pc_branch;
        logic [CTRL_W-1:0]     ctrl;
        logic                  zero;
    } entry_t;

    function automatic logic branch_taken(entry_t e);
        return e.ctrl[CTRL_BRANCH] & e.zero;
    endfunction

endpackage

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a one-deep skid slot so in_ready stays a
// registered signal; outputs always present the main (head) slot.
module ex_mem_stage
    import cpu_pkg::*;
#(
    parameter int n  = DEFAULT_N,
    parameter int RA = DEFAULT_RA
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [n-1:0]  alu_out,
    input  logic          zeroo,
    input  logic [n-1:0]  wdata,
    input  logic [RA-1:0] waddr,
    input  logic [n-1:0]  pc_branch,
    input  logic [3:0]    ctrl,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [n-1:0]  out_alu,
    output logic [n-1:0]  out_wdata,
    output logic [n-1:0]  out_pc_branch,
    output logic [RA-1:0] out_waddr,
    output logic [3:0]    out_ctrl,
    output logic          pcsrc,
    input  logic          flush
);

    stage_state_t state;
    entry_t       main_p0;
    entry_t       skid_p0;
    entry_t       in_entry;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         pcsrc_q;
    logic         accept;
    logic         retire;

    assign in_entry = '{alu:       alu_out,
                        wdata:     wdata,
                        waddr:     waddr,
                        pc_branch: pc_branch,
                        ctrl:      ctrl,
                        zero:      zeroo};

    assign accept = in_valid & in_ready_q;
    assign retire = out_valid_q & out_ready;

    // pcsrc is recomputed whenever the head entry changes, so it stays registered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= EMPTY;
            main_p0     <= '0;
            skid_p0     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            pcsrc_q     <= 1'b0;
        end else if (flush) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            pcsrc_q     <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_p0     <= in_entry;
                        state       <= ONE;
                        out_valid_q <= 1'b1;
                        pcsrc_q     <= branch_taken(in_entry);
                    end
                end
                ONE: begin
                    if (accept && retire) begin
                        main_p0 <= in_entry;
                        pcsrc_q <= branch_taken(in_entry);
                    end else if (accept) begin
                        skid_p0    <= in_entry;
                        state      <= FULL;
                        in_ready_q <= 1'b0;
                    end else if (retire) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                        pcsrc_q     <= 1'b0;
                    end
                end
                FULL: begin
                    if (retire) begin
                        main_p0    <= skid_p0;
                        state      <= ONE;
                        in_ready_q <= 1'b1;
                        pcsrc_q    <= branch_taken(skid_p0);
                    end
                end
                default: begin
                    state       <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    pcsrc_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign pcsrc         = pcsrc_q;
    assign out_alu       = main_p0.alu;
    assign out_wdata     = main_p0.wdata;
    assign out_waddr     = main_p0.waddr;
    assign out_pc_branch = main_p0.pc_branch;
    assign out_ctrl      = main_p0.ctrl;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: a queue model of the two-entry stage checked every
// cycle, plus directed scenarios with literal expectations.
module tb_ex_mem_stage;
    import cpu_pkg::*;

    localparam int N = 16;
    localparam int R = 4;

    logic          clk = 1'b0;
    logic          rst_n, in_valid, in_ready, zeroo, out_valid, out_ready, pcsrc, flush;
    logic [N-1:0]  alu_out, wdata, pc_branch, out_alu, out_wdata, out_pc_branch;
    logic [R-1:0]  waddr, out_waddr;
    logic [3:0]    ctrl, out_ctrl;

    always #5 clk = ~clk;

    ex_mem_stage #(.n(N), .RA(R)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .zeroo(zeroo), .wdata(wdata), .waddr(waddr),
        .pc_branch(pc_branch), .ctrl(ctrl), .out_valid(out_valid),
        .out_ready(out_ready), .out_alu(out_alu), .out_wdata(out_wdata),
        .out_pc_branch(out_pc_branch), .out_waddr(out_waddr),
        .out_ctrl(out_ctrl), .pcsrc(pcsrc), .flush(flush)
    );

    typedef struct {
        logic [15:0] alu;
        logic [15:0] wd;
        logic [15:0] pcb;
        logic [3:0]  wa;
        logic [3:0]  ct;
        logic        z;
    } mentry_t;

    mentry_t     mq[$];
    logic [15:0] log_q[$];
    int          passed = 0;
    int          total  = 0;
    bit          chk_en = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: FIFO of at most two entries; the head is what the outputs show.
    always @(posedge clk) begin
        mentry_t e;
        bit acc, ret;
        if (!rst_n || flush) begin
            mq.delete();
        end else begin
            acc = in_valid && (mq.size() < 2);
            ret = (mq.size() > 0) && out_ready;
            if (ret) void'(mq.pop_front());
            if (acc) begin
                e = '{alu: alu_out, wd: wdata, pcb: pc_branch, wa: waddr, ct: ctrl, z: zeroo};
                mq.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", out_valid, mq.size() > 0);
            check("in_ready", in_ready, mq.size() < 2);
            if (mq.size() > 0) begin
                check("out_alu", out_alu, mq[0].alu);
                check("out_wdata", out_wdata, mq[0].wd);
                check("out_waddr", out_waddr, mq[0].wa);
                check("out_pc_branch", out_pc_branch, mq[0].pcb);
                check("out_ctrl", out_ctrl, mq[0].ct);
                check("pcsrc", pcsrc, mq[0].ct[CTRL_BRANCH] & mq[0].z);
            end else begin
                check("pcsrc_idle", pcsrc, 0);
            end
            if (rst_n && !flush && out_valid && out_ready) log_q.push_back(out_alu);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(logic [15:0] a, logic [3:0] c, logic z, logic [15:0] pb);
        logic [15:0] t;
        t         = a;
        in_valid  = 1'b1;
        alu_out   = a;
        wdata     = a ^ 16'hffff;
        waddr     = t[3:0];
        pc_branch = pb;
        ctrl      = c;
        zeroo     = z;
    endtask

    task automatic wait_accept(string name);
        bit rdy;
        int cnt;
        cnt = 0;
        do begin
            @(negedge clk);
            rdy = in_ready;
            tick();
            cnt++;
        end while (!rdy && cnt < 50);
        if (!rdy) begin
            total++;
            $display("FAIL %s: accept timed out, got in_ready=0 expected accept within 50 cycles", name);
        end
    endtask

    task automatic send(string name, logic [15:0] a, logic [3:0] c, logic z, logic [15:0] pb);
        drive(a, c, z, pb);
        wait_accept(name);
        in_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] exp3 [3];
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        alu_out = '0; wdata = '0; waddr = '0; pc_branch = '0; ctrl = '0; zeroo = 1'b0;

        // Reset state
        tick();
        chk_en = 1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_alu", out_alu, 0);
        check("rst_pcsrc", pcsrc, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single entry, one-cycle latency, then empty
        log_q.delete();
        out_ready = 1'b1;
        send("single", 16'h1234, 4'b1000, 1'b0, 16'h0000);
        @(negedge clk);
        check("single_valid", out_valid, 1);
        check("single_alu", out_alu, 16'h1234);
        tick();
        @(negedge clk);
        check("single_empty", out_valid, 0);
        tick();
        check("single_count", log_q.size(), 1);

        // Backpressure: two accepts fill the stage, third waits upstream
        log_q.delete();
        out_ready = 1'b0;
        send("bp1", 16'h0001, 4'b1000, 1'b0, 16'h0000);
        send("bp2", 16'h0002, 4'b1000, 1'b0, 16'h0000);
        drive(16'h0003, 4'b1000, 1'b0, 16'h0000);
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        wait_accept("bp3");
        in_valid = 1'b0;
        repeat (4) tick();
        exp3 = '{16'h0001, 16'h0002, 16'h0003};
        check("bp_count", log_q.size(), 3);
        for (int i = 0; i < 3 && i < log_q.size(); i++) check("bp_order", log_q[i], exp3[i]);

        // Branch taken / not taken
        out_ready = 1'b1;
        send("br_taken", 16'h0005, 4'b0001, 1'b1, 16'h0040);
        @(negedge clk);
        check("br_pcsrc1", pcsrc, 1);
        check("br_pcb", out_pc_branch, 16'h0040);
        tick();
        send("br_not", 16'h0006, 4'b0001, 1'b0, 16'h0040);
        @(negedge clk);
        check("br_valid", out_valid, 1);
        check("br_pcsrc0", pcsrc, 0);
        tick();
        tick();

        // Flush in FULL with simultaneous in_valid
        out_ready = 1'b0;
        send("fl1", 16'h00a1, 4'b1000, 1'b0, 16'h0000);
        send("fl2", 16'h00a2, 4'b1000, 1'b0, 16'h0000);
        log_q.delete();
        drive(16'h00a3, 4'b1000, 1'b0, 16'h0000);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("fl_valid", out_valid, 0);
        check("fl_in_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (3) tick();
        check("fl_emitted", log_q.size(), 0);

        // Flush beats accept in EMPTY
        drive(16'h00b1, 4'b1000, 1'b0, 16'h0000);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("fl_acc_valid", out_valid, 0);
        tick();

        // Streaming 1..8
        log_q.delete();
        out_ready = 1'b1;
        for (int v = 1; v <= 8; v++) begin
            drive(16'(v), 4'b1100, 1'b0, 16'h0000);
            @(negedge clk);
            check("stream_ready", in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        check("stream_count", log_q.size(), 8);
        for (int i = 0; i < 8 && i < log_q.size(); i++) check("stream_order", log_q[i], 16'(i + 1));

        // Reset while FULL
        out_ready = 1'b0;
        send("rf1", 16'h00aa, 4'b1111, 1'b1, 16'h0080);
        send("rf2", 16'h00bb, 4'b1111, 1'b1, 16'h0090);
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        check("rf_valid", out_valid, 0);
        check("rf_in_ready", in_ready, 1);
        check("rf_alu", out_alu, 0);
        check("rf_wdata", out_wdata, 0);
        check("rf_waddr", out_waddr, 0);
        check("rf_pcb", out_pc_branch, 0);
        check("rf_ctrl", out_ctrl, 0);
        check("rf_pcsrc", pcsrc, 0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        chk_en = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
